knowles_pipe_adder: RTL

Parametrised, pipelined successor to the 32-bit radix-2 Knowles carry-lookahead adder. It supports a configurable operand width, a single uniform Knowles fanout, and a selectable register boundary after any prefix stage. It adds add/subtract mode, a signed-overflow flag and a valid/ready handshake on both sides. It sits in the datapath wherever a throughput-of-one adder must close timing at widths or clock rates the combinational adder cannot.

---
 rtl/knowles_pipe_adder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/knowles_pipe_adder.sv
// knowles_pipe_adder: parametrised, pipelined radix-2 Knowles prefix adder.
// Supports add/subtract, produces a signed-overflow flag, and uses a valid/ready
// handshake on both sides. Index 0 of the prefix vectors holds the carry-in.
// Index i (1..WIDTH-1) holds operand bit i. The prefix tree does not combine
// the top bit, WIDTH. A register may follow any prefix stage, and a result
// register always sits at the output.
module knowles_pipe_adder #(
    parameter int                       WIDTH     = 32,
    parameter int                       FANOUT    = 1,
    parameter logic [$clog2(WIDTH)-1:0] PIPE_MASK = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:1]   A,
    input  logic [WIDTH:1]   B,
    input  logic             Ci,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:1]   S,
    output logic             Co,
    output logic             V
);

    localparam int N = $clog2(WIDTH);

    // Fanout used by prefix stage k. It is capped at the group size of that stage.
    function automatic int fan(input int k);
        int half;
        half = 1 << (k - 1);
        return (FANOUT < half) ? FANOUT : half;
    endfunction

    // Index of the lower node that feeds node i at prefix stage k.
    function automatic int lower_idx(input int k, input int i);
        return (i | (fan(k) - 1)) - (1 << (k - 1));
    endfunction

    // Returns 1 when node i already spans down to index 0 after k prefix stages.
    function automatic logic resolved(input int k, input int i);
        int lo  [WIDTH];
        int nxt [WIDTH];
        int j;
        for (int x = 0; x < WIDTH; x++) lo[x] = x;
        for (int s = 1; s <= k; s++) begin
            for (int x = 0; x < WIDTH; x++) begin
                nxt[x] = lo[x];
                if (lo[x] != 0) begin
                    j = lower_idx(s, x);
                    if (j >= 0) nxt[x] = lo[j];
                end
            end
            lo = nxt;
        end
        return lo[i] == 0;
    endfunction

    // Returns 1 when a pipeline register follows prefix stage k. The last stage
    // never gets one here, because the output register takes its place.
    function automatic logic has_reg(input int k);
        logic r;
        r = 1'b0;
        if (k >= 1 && k < N) r = PIPE_MASK[k-1];
        return r;
    endfunction

    // A single advance signal drives every stage, so the whole pipe shifts or holds together.
    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    logic [WIDTH:1] bx;
    logic           c0;
    assign bx = Sub ? ~B : B;
    assign c0 = Sub | Ci;

    for (genvar k = 0; k <= N; k++) begin : stg
        // Comb outputs of stage k, then the same values after the optional register.
        logic [WIDTH-1:0] g, p, g_q, p_q;
        logic [WIDTH:1]   pb, pb_q;
        logic             a_w, bx_w, v, a_w_q, bx_w_q, v_q;

        if (k == 0) begin : bitwise
            assign g    = {A[WIDTH-1:1] & bx[WIDTH-1:1], c0};
            assign p    = {A[WIDTH-1:1] ^ bx[WIDTH-1:1], 1'b0};
            assign pb   = A ^ bx;
            assign a_w  = A[WIDTH];
            assign bx_w = bx[WIDTH];
            assign v    = in_valid;
        end else begin : prefix
            assign pb   = stg[k-1].pb_q;
            assign a_w  = stg[k-1].a_w_q;
            assign bx_w = stg[k-1].bx_w_q;
            assign v    = stg[k-1].v_q;
            for (genvar i = 0; i < WIDTH; i++) begin : node
                if (resolved(k - 1, i) || (lower_idx(k, i) < 0)) begin : pass
                    assign g[i] = stg[k-1].g_q[i];
                    assign p[i] = stg[k-1].p_q[i];
                end else if (resolved(k - 1, lower_idx(k, i))) begin : g_only
                    localparam int J = lower_idx(k, i);
                    assign g[i] = stg[k-1].g_q[i] | (stg[k-1].p_q[i] & stg[k-1].g_q[J]);
                    assign p[i] = 1'b0;
                end else begin : g_and_p
                    localparam int J = lower_idx(k, i);
                    assign g[i] = stg[k-1].g_q[i] | (stg[k-1].p_q[i] & stg[k-1].g_q[J]);
                    assign p[i] = stg[k-1].p_q[i] & stg[k-1].p_q[J];
                end
            end
        end

        if (has_reg(k)) begin : pipe_reg
            // Valid bit of this boundary: cleared by reset, shifts on advance.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                end else if (adv) begin
                    // NOTE: non-blocking so each stage captures its predecessor's pre-edge value.
                    v_q <= v;
                end
            end

            // NOTE: datapath bits have no reset; they are meaningless while v_q is low.
            // Datapath payload of this boundary: shifts on advance and holds on stall.
            always_ff @(posedge clk) begin
                if (adv) begin
                    g_q    <= g;
                    p_q    <= p;
                    pb_q   <= pb;
                    a_w_q  <= a_w;
                    bx_w_q <= bx_w;
                end
            end
        end else begin : no_reg
            assign g_q    = g;
            assign p_q    = p;
            assign pb_q   = pb;
            assign a_w_q  = a_w;
            assign bx_w_q = bx_w;
            assign v_q    = v;
        end
    end

    // The output logic forms the sum, carry-out and overflow from the fully resolved prefix carries.
    logic [WIDTH:1] s_c;
    logic           co_c, v_c;
    assign s_c  = stg[N].pb_q ^ stg[N].g_q;
    assign co_c = (stg[N].a_w_q & stg[N].bx_w_q) | (stg[N].pb_q[WIDTH] & stg[N].g_q[WIDTH-1]);
    assign v_c  = (stg[N].a_w_q == stg[N].bx_w_q) & (s_c[WIDTH] != stg[N].a_w_q);

    // The last-stage group propagate is not needed once every carry is resolved.
    logic unused_p;
    assign unused_p = ^stg[N].p_q;

    // Result register: loads only valid results, so bubbles and stalls leave S/Co/V untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            S         <= '0;
            Co        <= 1'b0;
            V         <= 1'b0;
        end else if (adv) begin
            out_valid <= stg[N].v_q;
            if (stg[N].v_q) begin
                S  <= s_c;
                Co <= co_c;
                V  <= v_c;
            end
        end
    end

endmodule
